// File: rtl/lut_cfg_loader.sv
// Bit-serial loader that assembles LUT truth-table masks and commits them atomically.
// Optional even-parity trailer beat enabled by defining LUT_CFG_PARITY_EN.
module lut_cfg_loader #(
  parameter int                     NUM_LUTS = 4,
  parameter logic [NUM_LUTS*16-1:0] INIT     = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic                     cfg_bit,
  input  logic                     cfg_last,
  output logic [NUM_LUTS*16-1:0]   lut_cfg,
  output logic                     cfg_commit,
  output logic                     cfg_err,
  output logic                     busy
);

  localparam int FD = NUM_LUTS * 16;
`ifdef LUT_CFG_PARITY_EN
  localparam int FRAME = FD + 1;
`else
  localparam int FRAME = FD;
`endif
  localparam int CW = $clog2(FRAME + 1);
  localparam logic [CW-1:0] LAST  = CW'(FRAME - 1);
  localparam logic [CW-1:0] NDATA = CW'(FD);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_COMMIT
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [FD-1:0] r_shadow;
  logic [FD-1:0] r_lut;
  logic          r_commit;
  logic          r_err;
  logic          w_err_nxt;
  logic          w_beat;
  logic          w_shift;
  logic          w_par_ok;

  assign cfg_ready  = (r_state != S_COMMIT);
  assign w_beat     = cfg_valid & cfg_ready;
  assign w_shift    = w_beat & (r_cnt < NDATA);
  assign lut_cfg    = r_lut;
  assign cfg_commit = r_commit;
  assign cfg_err    = r_err;
  assign busy       = (r_state != S_IDLE) | (r_cnt != '0);

`ifdef LUT_CFG_PARITY_EN
  logic r_par;

  // r_par holds the XOR of all data bits when the trailer beat arrives
  assign w_par_ok = (r_par == cfg_bit);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_par <= 1'b0;
    end else if (w_shift) begin
      r_par <= (r_cnt == '0) ? cfg_bit : (r_par ^ cfg_bit);
    end
  end
`else
  assign w_par_ok = 1'b1;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = 1'b0;
    case (r_state)
      S_COMMIT: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        if (w_beat) begin
          if (r_cnt != LAST) begin
            if (cfg_last) begin
              w_err_nxt   = 1'b1;
              w_cnt_nxt   = '0;
              w_state_nxt = S_IDLE;
            end else begin
              w_cnt_nxt   = r_cnt + CW'(1);
              w_state_nxt = S_SHIFT;
            end
          end else begin
            w_cnt_nxt = '0;
            if (cfg_last && w_par_ok) begin
              w_state_nxt = S_COMMIT;
            end else begin
              w_err_nxt   = 1'b1;
              w_state_nxt = S_IDLE;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_shadow <= '0;
      r_lut    <= INIT;
      r_commit <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_err    <= w_err_nxt;
      r_commit <= (r_state == S_COMMIT);
      if (w_shift) begin
        r_shadow <= {r_shadow[FD-2:0], cfg_bit};
      end
      if (r_state == S_COMMIT) begin
        r_lut <= r_shadow;
      end
    end
  end

endmodule

// File: doc/lut_cfg_loader.md
Name: lut_cfg_loader

Overview:
- Serial configuration loader that sits directly upstream of a bank of 4-input `lut` cells and supplies their 16-bit truth-table masks at runtime.
- Accepts a bit-serial frame over a valid/ready handshake and assembles it in a shadow register.
- On a correctly terminated frame, atomically commits all masks to the active configuration output and pulses a commit strobe.
- Malformed frames are discarded and flagged; the active configuration is never partially updated.

Parameters:
- NUM_LUTS, 4, number of LUT masks per frame (>=1).
- INIT, {NUM_LUTS*16{1'b0}}, value of lut_cfg after reset.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_valid  in  1  cfg_bit/cfg_last are valid.
- cfg_ready  out  1  loader accepts a beat this cycle.
- cfg_bit  in  1  serial config bit, MSB-first.
- cfg_last  in  1  marks the final beat of a frame.
- lut_cfg  out  NUM_LUTS*16  active masks; LUT k uses lut_cfg[16k+15:16k].
- cfg_commit  out  1  one-cycle pulse when lut_cfg takes a new value.
- cfg_err  out  1  one-cycle pulse when a frame is rejected.
- busy  out  1  high while a frame is partially received or a commit is pending.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, bit counter=0, shadow=0, lut_cfg=INIT, cfg_commit=0, cfg_err=0. cfg_ready is 1 in the first cycle after reset.
- Beat: cfg_valid & cfg_ready in the same cycle. No beat means no state change, and cfg_bit/cfg_last are ignored.
- FRAME = NUM_LUTS*16 (+1 with parity, see Optional Feature). The counter is $clog2(FRAME+1) bits wide.
- Shift order: on each beat, shadow <= {shadow[FRAME_DATA-2:0], cfg_bit}. The first bit of a frame ends up in lut_cfg[NUM_LUTS*16-1], i.e. the MSB of LUT NUM_LUTS-1.
- States:
  - IDLE (cnt==0) and SHIFT (cnt>0): cfg_ready=1.
  - COMMIT: cfg_ready=0.
- Transitions on a beat:
  - cnt<FRAME-1 and !cfg_last: cnt++, state SHIFT.
  - cnt<FRAME-1 and cfg_last (short frame): cfg_err=1 next cycle, cnt<=0, shadow discarded, state IDLE.
  - cnt==FRAME-1 and !cfg_last (overlong frame): cfg_err=1 next cycle, cnt<=0, state IDLE. The beat is consumed; the sender must resynchronise by starting a new frame.
  - cnt==FRAME-1 and cfg_last (and check passes): state COMMIT, cnt<=0.
- COMMIT (exactly one cycle): on its closing edge, lut_cfg<=shadow data bits, cfg_commit<=1, state IDLE.
- Latency: a final beat in cycle t gives new lut_cfg and cfg_commit=1 in cycle t+2. cfg_ready=0 in cycle t+1 only.
- cfg_commit and cfg_err are registered and high for exactly one cycle. They are never high together.
- busy = (state!=IDLE) | (cnt!=0), combinational from registers.
- lut_cfg changes only at a commit or on reset. It never glitches during shifting.
- Reset mid-frame: the partial frame is discarded and lut_cfg returns to INIT. Reset during COMMIT: no commit and no pulse; reset values apply.
- rst has priority over every beat in the same cycle.

Optional Feature:
- Macro: LUT_CFG_PARITY_EN.
- Defined:
  - Frame is NUM_LUTS*16+1 beats. The final beat (carrying cfg_last) is an even-parity bit over all data bits and is not shifted into the shadow register.
  - A running XOR register is cleared at frame start and on reset.
  - If the parity bit does not equal the XOR of the data bits: cfg_err pulse, no commit, state IDLE.
- Undefined:
  - Frame is NUM_LUTS*16 beats, with cfg_last on the last data bit.
  - No parity logic is instantiated.

Test Plan:
1. Reset -> with rst held 2 cycles: lut_cfg==INIT (0), cfg_commit=0, cfg_err=0, busy=0, cfg_ready=1 on the first post-reset cycle.
2. NUM_LUTS=4, contiguous frame of 64 bits MSB-first with masks LUT3=16'hFFD2, LUT2=16'h0000, LUT1=16'hFFFF, LUT0=16'hA5A5, cfg_last on bit 64 -> cfg_ready=0 one cycle later; two cycles after the last beat, lut_cfg==64'hFFD2_0000_FFFF_A5A5 and cfg_commit is a single one-cycle pulse. A lut driven by lut_cfg[63:48] then matches ((a&~b)^c)|d on all 16 input combinations.
3. Same frame, but cfg_valid gated pseudo-randomly by a 64-bit xorshift generator (~50% duty) -> identical lut_cfg and exactly one commit; no change while bits are idle.
4. cfg_last on beat 10 -> cfg_err pulses once, no commit, lut_cfg unchanged, busy=0. A subsequent full frame with value 64'h1234_5678_9ABC_DEF0 commits correctly.
5. 65 beats without cfg_last at beat 64 -> cfg_err at beat 64. Also assert rst after 30 beats of a valid frame -> lut_cfg==INIT, cnt cleared; the next full frame commits.
6. With LUT_CFG_PARITY_EN: frame of test 2 plus correct parity bit (0) -> commit. The same frame with parity bit 1 -> cfg_err, lut_cfg unchanged.
